// File: rtl/branch_history_table_if.sv
// Update and prediction bus of the branch history table.
// The frontend drives updates; the BHT drives one prediction per slot.
interface branch_history_table_if #(
  parameter int unsigned VLEN     = 32,
  parameter int unsigned IPF      = 2,
  parameter int unsigned IDX_BITS = 4
);
  logic                          upd_valid;
  logic [VLEN-1:0]               upd_pc;
  logic                          upd_taken;
  logic [IDX_BITS-1:0]           upd_index;
  logic [IPF-1:0]                pred_valid;
  logic [IPF-1:0]                pred_taken;
  logic [IPF-1:0][IDX_BITS-1:0]  pred_index;

  modport master (
    output upd_valid, upd_pc, upd_taken, upd_index,
    input  pred_valid, pred_taken, pred_index
  );

  modport slave (
    input  upd_valid, upd_pc, upd_taken, upd_index,
    output pred_valid, pred_taken, pred_index
  );
endinterface

// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating counters, one RAM bank per slot.
// Predictions are combinational; updates read-modify-write a single row.
module bht_ram #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned AW   = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] raddr_i,
  output logic [2:0]    rdata_o,
  input  logic [AW-1:0] uaddr_i,
  output logic [2:0]    udata_o,
  input  logic [2:0]    wdata_i
);
  // {valid, counter[1:0]}; intentionally not reset
  logic [2:0] mem [ROWS];

  assign rdata_o = mem[raddr_i];
  assign udata_o = mem[uaddr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[uaddr_i] <= wdata_i;
  end
endmodule

module branch_history_table #(
  parameter int unsigned VLEN       = 32,
  parameter int unsigned IPF        = 2,
  parameter bit          RVC        = 1'b1,
  parameter int unsigned NR_ENTRIES = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_bp_i,
  input  logic             debug_mode_i,
  input  logic [VLEN-1:0]  vpc_i,
  branch_history_table_if.slave bus
);
  localparam int unsigned NR_ROWS = NR_ENTRIES / IPF;
  localparam int unsigned IDX     = $clog2(NR_ROWS);
  localparam int unsigned OFFSET  = RVC ? 1 : 2;
  localparam int unsigned RAB     = $clog2(IPF);
  localparam int unsigned BW      = (IPF > 1) ? RAB : 1;

  logic [IDX-1:0] rd_idx;
  logic [BW-1:0]  upd_bank;
  logic           upd_en;
  logic           unused_ok;

  assign rd_idx = vpc_i[OFFSET+RAB+IDX-1 -: IDX];
  assign upd_en = bus.upd_valid & ~debug_mode_i & rst_ni;

  // flush is accepted but has no effect on this predictor
  assign unused_ok = &{1'b0, flush_bp_i, vpc_i, bus.upd_pc};

  generate
    if (IPF > 1) begin : gen_bank_sel
      assign upd_bank = bus.upd_pc[OFFSET+RAB-1 -: RAB];
    end else begin : gen_bank_zero
      assign upd_bank = '0;
    end
  endgenerate

  function automatic logic [1:0] sat_next(
    input logic [1:0] cnt,
    input logic       taken
  );
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'b01;
    end
    return res;
  endfunction

  genvar b;
  generate
    for (b = 0; b < IPF; b++) begin : gen_bht_ram
      logic [2:0] rdata;
      logic [2:0] udata;
      logic [2:0] wdata;
      logic       we;

      assign we    = upd_en && (upd_bank == BW'(b));
      assign wdata = {1'b1, sat_next(udata[1:0], bus.upd_taken)};

      bht_ram #(
        .ROWS (NR_ROWS),
        .AW   (IDX)
      ) i_bht_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .raddr_i (rd_idx),
        .rdata_o (rdata),
        .uaddr_i (bus.upd_index),
        .udata_o (udata),
        .wdata_i (wdata)
      );

      assign bus.pred_valid[b] = rdata[2];
      assign bus.pred_taken[b] = rdata[1];
      assign bus.pred_index[b] = rd_idx;
    end
  endgenerate
endmodule

// File: tb/tb_branch_history_table.sv
// Directed and random bench for branch_history_table.
// Default config: 2 slots, RVC, 32 entries, read index = vpc[5:2].
module tb_branch_history_table;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush;
  logic        debug;
  logic [31:0] vpc;
  logic [2:0]  shadow [2][16];
  int          pass_cnt = 0;
  int          total = 0;

  always #5 clk = ~clk;

  branch_history_table_if #(
    .VLEN(32), .IPF(2), .IDX_BITS(4)
  ) bus ();

  branch_history_table #(
    .VLEN(32), .IPF(2), .RVC(1'b1), .NR_ENTRIES(32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_bp_i   (flush),
    .debug_mode_i (debug),
    .vpc_i        (vpc),
    .bus          (bus)
  );

  task automatic poke(input int b, input int r, input logic [2:0] w);
    if (b == 0) dut.gen_bht_ram[0].i_bht_ram.mem[r] = w;
    else        dut.gen_bht_ram[1].i_bht_ram.mem[r] = w;
    shadow[b][r] = w;
  endtask

  function automatic logic [2:0] peek(input int b, input int r);
    if (b == 0) return dut.gen_bht_ram[0].i_bht_ram.mem[r];
    return dut.gen_bht_ram[1].i_bht_ram.mem[r];
  endfunction

  function automatic logic [5:0] pred(input int b);
    return {bus.pred_valid[b], bus.pred_taken[b], bus.pred_index[b]};
  endfunction

  function automatic logic [2:0] model_upd(input logic [2:0] w, input logic t);
    logic [1:0] c;
    c = w[1:0];
    if (t && c < 2'd3) c = c + 2'd1;
    else if (!t && c > 2'd0) c = c - 2'd1;
    return {1'b1, c};
  endfunction

  task automatic set_upd(input logic v, input logic [31:0] pc,
                         input logic [3:0] idx, input logic t);
    bus.upd_valid = v;
    bus.upd_pc    = pc;
    bus.upd_index = idx;
    bus.upd_taken = t;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    flush  = 1'b0;
    debug  = 1'b0;
    set_upd(1'b0, 32'h0, 4'h0, 1'b0);
    poke(0, 2, 3'b110);
    vpc = 32'h08;
    #1;
    total++;
    if (pred(0) !== 6'b11_0010) $display("FAIL reset_pred got %b want %b", pred(0), 6'b11_0010);
    else pass_cnt++;
    set_upd(1'b1, 32'h0, 4'd2, 1'b0);
    @(posedge clk); #1;
    total++;
    if (peek(0, 2) !== 3'b110) $display("FAIL reset_upd got %b want %b", peek(0, 2), 3'b110);
    else pass_cnt++;
    set_upd(1'b0, 32'h0, 4'h0, 1'b0);
    rst_ni = 1'b1;
  endtask

  task automatic test_read;
    @(posedge clk); #1;
    poke(0, 3, 3'b111);
    poke(1, 3, 3'b010);
    vpc = 32'h0C;
    #1;
    total++;
    if (pred(0) !== 6'b11_0011) $display("FAIL read_p0 got %b want %b", pred(0), 6'b11_0011);
    else pass_cnt++;
    total++;
    if (pred(1) !== 6'b01_0011) $display("FAIL read_p1 got %b want %b", pred(1), 6'b01_0011);
    else pass_cnt++;
  endtask

  task automatic test_sat_up;
    logic [2:0] exp_w [4];
    exp_w = '{3'b101, 3'b110, 3'b111, 3'b111};
    @(posedge clk); #1;
    poke(1, 5, 3'b000);
    set_upd(1'b1, 32'h16, 4'd5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (peek(1, 5) !== exp_w[i]) $display("FAIL sat_up_%0d got %b want %b", i, peek(1, 5), exp_w[i]);
      else pass_cnt++;
    end
    set_upd(1'b0, 32'h0, 4'h0, 1'b0);
    vpc = 32'h14;
    #1;
    total++;
    if (pred(1) !== 6'b11_0101) $display("FAIL sat_up_pred got %b want %b", pred(1), 6'b11_0101);
    else pass_cnt++;
  endtask

  task automatic test_sat_down;
    @(posedge clk); #1;
    poke(0, 0, 3'b101);
    set_upd(1'b1, 32'h0, 4'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (peek(0, 0) !== 3'b100) $display("FAIL sat_dn_%0d got %b want %b", i, peek(0, 0), 3'b100);
      else pass_cnt++;
    end
    set_upd(1'b0, 32'h0, 4'h0, 1'b0);
    vpc = 32'h0;
    #1;
    total++;
    if (pred(0) !== 6'b10_0000) $display("FAIL sat_dn_pred got %b want %b", pred(0), 6'b10_0000);
    else pass_cnt++;
  endtask

  task automatic test_suppress;
    @(posedge clk); #1;
    poke(0, 4, 3'b010);
    debug = 1'b1;
    set_upd(1'b1, 32'h0, 4'd4, 1'b1);
    @(posedge clk); #1;
    total++;
    if (peek(0, 4) !== 3'b010) $display("FAIL debug_drop got %b want %b", peek(0, 4), 3'b010);
    else pass_cnt++;
    debug  = 1'b0;
    rst_ni = 1'b0;
    vpc    = 32'h10;
    @(posedge clk); #1;
    total++;
    if (peek(0, 4) !== 3'b010) $display("FAIL rst_drop got %b want %b", peek(0, 4), 3'b010);
    else pass_cnt++;
    total++;
    if (pred(0) !== 6'b01_0100) $display("FAIL rst_pred got %b want %b", pred(0), 6'b01_0100);
    else pass_cnt++;
    rst_ni = 1'b1;
    flush  = 1'b1;
    @(posedge clk); #1;
    total++;
    if (peek(0, 4) !== 3'b111) $display("FAIL flush_upd got %b want %b", peek(0, 4), 3'b111);
    else pass_cnt++;
    flush = 1'b0;
    set_upd(1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_same_cycle;
    @(posedge clk); #1;
    poke(0, 7, 3'b101);
    vpc = 32'h1C;
    set_upd(1'b1, 32'h0, 4'd7, 1'b1);
    @(negedge clk);
    total++;
    if (pred(0) !== 6'b10_0111) $display("FAIL same_old got %b want %b", pred(0), 6'b10_0111);
    else pass_cnt++;
    @(posedge clk); #1;
    set_upd(1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    total++;
    if (pred(0) !== 6'b11_0111) $display("FAIL same_new got %b want %b", pred(0), 6'b11_0111);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [5:0] e0, e1;
    logic [3:0] ri;
    int         bank;
    int         errs;
    errs = 0;
    @(posedge clk); #1;
    for (int r = 0; r < 16; r++) begin
      poke(0, r, 3'($urandom));
      poke(1, r, 3'($urandom));
    end
    for (int c = 0; c < 10000; c++) begin
      vpc   = $urandom;
      debug = ($urandom_range(0, 9) == 0);
      set_upd($urandom_range(0, 1) == 1, $urandom, 4'($urandom), 1'($urandom));
      @(negedge clk);
      ri = vpc[5:2];
      e0 = {shadow[0][ri][2], shadow[0][ri][1], ri};
      e1 = {shadow[1][ri][2], shadow[1][ri][1], ri};
      total++;
      if ({pred(0), pred(1)} !== {e0, e1}) begin
        if (errs < 10)
          $display("FAIL rand_pred cyc %0d got %b want %b", c, {pred(0), pred(1)}, {e0, e1});
        errs++;
      end else pass_cnt++;
      @(posedge clk);
      if (bus.upd_valid && !debug) begin
        bank = int'(bus.upd_pc[1]);
        shadow[bank][bus.upd_index] = model_upd(shadow[bank][bus.upd_index], bus.upd_taken);
      end
      #1;
    end
    set_upd(1'b0, 32'h0, 4'h0, 1'b0);
    debug = 1'b0;
    for (int r = 0; r < 16; r++) begin
      total++;
      if ({peek(0, r), peek(1, r)} !== {shadow[0][r], shadow[1][r]})
        $display("FAIL rand_mem row %0d got %b want %b", r, {peek(0, r), peek(1, r)}, {shadow[0][r], shadow[1][r]});
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_sat_up();
    test_sat_down();
    test_suppress();
    test_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
